// File: rtl/config_cmd_parser.sv
// ASCII config-line parser: turns "C<type> [v1] [v2]<CR|LF>" into a one-cycle
// command for config_manager, then reports a one-cycle result code.
module config_cmd_parser #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              config_valid,
    output logic [2:0]        config_type,
    output logic signed [7:0] config_value1,
    output logic signed [7:0] config_value2,
    input  logic              config_done,
    input  logic              config_error,
    output logic              resp_valid,
    output logic [1:0]        resp_code,
    output logic              busy
);

    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] RESP_OK      = 2'd0;
    localparam logic [1:0] RESP_REJECT  = 2'd1;
    localparam logic [1:0] RESP_PARSE   = 2'd2;
    localparam logic [1:0] RESP_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TYPE,
        S_SEP,
        S_SIGN,
        S_DIGIT,
        S_ERR_SKIP,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t            state_reg, state_next;
    logic [2:0]        type_reg, type_next;
    logic              neg_reg, neg_next;
    logic [9:0]        mag_reg, mag_next;
    logic [1:0]        dig_reg, dig_next;
    logic [1:0]        count_reg, count_next;
    logic [7:0]        field0_reg, field0_next;
    logic [7:0]        field1_reg, field1_next;
    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic [2:0]        cfg_type_reg;
    logic [7:0]        cfg_v1_reg, cfg_v2_reg;
    logic              resp_valid_reg;
    logic [1:0]        resp_code_reg;

    logic              resp_set;
    logic [1:0]        resp_code_next;
    logic              cfg_load;

    // Byte classification
    logic       is_c, is_digit, is_type_digit, is_space, is_minus, is_term;
    logic [7:0] digit_off;
    logic [3:0] digit_val;

    assign is_c          = (rx_data == 8'h43) || (rx_data == 8'h63);
    assign is_digit      = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_type_digit = (rx_data >= 8'h30) && (rx_data <= 8'h37);
    assign is_space      = (rx_data == 8'h20);
    assign is_minus      = (rx_data == 8'h2D);
    assign is_term       = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign digit_off     = rx_data - 8'h30;
    assign digit_val     = digit_off[3:0];

    // Field close: range check against the sign, plus the two-field limit
    logic       close_bad;
    logic [7:0] mag_low;
    logic [7:0] close_val;
    logic [9:0] mag_acc;

    assign mag_low   = mag_reg[7:0];
    assign close_val = neg_reg ? (8'd0 - mag_low) : mag_low;
    assign close_bad = (count_reg == 2'd2) ||
                       (neg_reg ? (mag_reg > 10'd128) : (mag_reg > 10'd127));
    assign mag_acc   = (mag_reg * 10'd10) + {6'd0, digit_val};

    always_comb begin
        state_next     = state_reg;
        type_next      = type_reg;
        neg_next       = neg_reg;
        mag_next       = mag_reg;
        dig_next       = dig_reg;
        count_next     = count_reg;
        field0_next    = field0_reg;
        field1_next    = field1_reg;
        wait_next      = wait_reg;
        resp_set       = 1'b0;
        resp_code_next = resp_code_reg;

        case (state_reg)
            S_IDLE: begin
                if (rx_valid && is_c) begin
                    state_next = S_TYPE;
                end
            end
            S_TYPE: begin
                if (rx_valid) begin
                    if (is_type_digit) begin
                        type_next  = rx_data[2:0];
                        state_next = S_SEP;
                    end else if (is_term) begin
                        resp_set       = 1'b1;
                        resp_code_next = RESP_PARSE;
                        state_next     = S_IDLE;
                    end else begin
                        state_next = S_ERR_SKIP;
                    end
                end
            end
            S_SEP: begin
                if (rx_valid) begin
                    if (is_space) begin
                        state_next = S_SEP;
                    end else if (is_minus) begin
                        neg_next   = 1'b1;
                        mag_next   = 10'd0;
                        dig_next   = 2'd0;
                        state_next = S_SIGN;
                    end else if (is_digit) begin
                        neg_next   = 1'b0;
                        mag_next   = {6'd0, digit_val};
                        dig_next   = 2'd1;
                        state_next = S_DIGIT;
                    end else if (is_term) begin
                        state_next = S_ISSUE;
                    end else begin
                        state_next = S_ERR_SKIP;
                    end
                end
            end
            S_SIGN: begin
                if (rx_valid) begin
                    if (is_digit) begin
                        mag_next   = {6'd0, digit_val};
                        dig_next   = 2'd1;
                        state_next = S_DIGIT;
                    end else if (is_term) begin
                        resp_set       = 1'b1;
                        resp_code_next = RESP_PARSE;
                        state_next     = S_IDLE;
                    end else begin
                        state_next = S_ERR_SKIP;
                    end
                end
            end
            S_DIGIT: begin
                if (rx_valid) begin
                    if (is_digit) begin
                        if (dig_reg == 2'd3) begin
                            state_next = S_ERR_SKIP;
                        end else begin
                            mag_next = mag_acc;
                            dig_next = dig_reg + 2'd1;
                        end
                    end else if (is_space || is_term) begin
                        if (close_bad) begin
                            if (is_term) begin
                                resp_set       = 1'b1;
                                resp_code_next = RESP_PARSE;
                                state_next     = S_IDLE;
                            end else begin
                                state_next = S_ERR_SKIP;
                            end
                        end else begin
                            if (count_reg == 2'd0) begin
                                field0_next = close_val;
                            end else begin
                                field1_next = close_val;
                            end
                            count_next = count_reg + 2'd1;
                            neg_next   = 1'b0;
                            mag_next   = 10'd0;
                            dig_next   = 2'd0;
                            state_next = is_term ? S_ISSUE : S_SEP;
                        end
                    end else begin
                        state_next = S_ERR_SKIP;
                    end
                end
            end
            S_ERR_SKIP: begin
                if (rx_valid && is_term) begin
                    resp_set       = 1'b1;
                    resp_code_next = RESP_PARSE;
                    state_next     = S_IDLE;
                end
            end
            S_ISSUE: begin
                wait_next  = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // A simultaneous done+error is reported as a rejection
                if (config_error) begin
                    resp_set       = 1'b1;
                    resp_code_next = RESP_REJECT;
                    state_next     = S_IDLE;
                end else if (config_done) begin
                    resp_set       = 1'b1;
                    resp_code_next = RESP_OK;
                    state_next     = S_IDLE;
                end else if (wait_reg == WAIT_LAST) begin
                    resp_set       = 1'b1;
                    resp_code_next = RESP_TIMEOUT;
                    state_next     = S_IDLE;
                end else begin
                    wait_next = wait_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Every return to IDLE starts the next line from a clean slate
        if (state_next == S_IDLE) begin
            neg_next    = 1'b0;
            mag_next    = 10'd0;
            dig_next    = 2'd0;
            count_next  = 2'd0;
            field0_next = 8'd0;
            field1_next = 8'd0;
        end
    end

    assign cfg_load = (state_next == S_ISSUE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            type_reg       <= 3'd0;
            neg_reg        <= 1'b0;
            mag_reg        <= 10'd0;
            dig_reg        <= 2'd0;
            count_reg      <= 2'd0;
            field0_reg     <= 8'd0;
            field1_reg     <= 8'd0;
            wait_reg       <= '0;
            cfg_type_reg   <= 3'd0;
            cfg_v1_reg     <= 8'd0;
            cfg_v2_reg     <= 8'd0;
            resp_valid_reg <= 1'b0;
            resp_code_reg  <= 2'd0;
        end else begin
            state_reg      <= state_next;
            type_reg       <= type_next;
            neg_reg        <= neg_next;
            mag_reg        <= mag_next;
            dig_reg        <= dig_next;
            count_reg      <= count_next;
            field0_reg     <= field0_next;
            field1_reg     <= field1_next;
            wait_reg       <= wait_next;
            resp_valid_reg <= resp_set;
            if (resp_set) begin
                resp_code_reg <= resp_code_next;
            end
            // Use the _next values so a field closed by the terminator is included
            if (cfg_load) begin
                cfg_type_reg <= type_next;
                cfg_v1_reg   <= field0_next;
                cfg_v2_reg   <= field1_next;
            end
        end
    end

    assign config_valid  = (state_reg == S_ISSUE);
    assign busy          = (state_reg == S_ISSUE) || (state_reg == S_WAIT);
    assign config_type   = cfg_type_reg;
    assign config_value1 = cfg_v1_reg;
    assign config_value2 = cfg_v2_reg;
    assign resp_valid    = resp_valid_reg;
    assign resp_code     = resp_code_reg;

endmodule

// File: tb/tb_config_cmd_parser.sv
// Directed bench for config_cmd_parser: sends ASCII lines, plays config_manager,
// and checks command fields, result codes and timing against hand-computed values.
module tb_config_cmd_parser;

    logic              clk;
    logic              rst_n;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              config_valid;
    logic [2:0]        config_type;
    logic signed [7:0] config_value1;
    logic signed [7:0] config_value2;
    logic              config_done;
    logic              config_error;
    logic              resp_valid;
    logic [1:0]        resp_code;
    logic              busy;

    int passed = 0;
    int total  = 0;

    // Passive monitor state, updated on every falling edge
    int         cyc = 0;
    int         cv_count = 0;
    int         rv_count = 0;
    int         cv_cyc = 0;
    int         rv_cyc = 0;
    logic [2:0] cv_type = 3'd0;
    logic [7:0] cv_v1 = 8'd0;
    logic [7:0] cv_v2 = 8'd0;
    logic [1:0] rv_code = 2'd0;

    // Results of the most recent do_line
    int d_cv;
    int d_rv;

    config_cmd_parser #(.TIMEOUT_CYCLES(15)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .config_valid  (config_valid),
        .config_type   (config_type),
        .config_value1 (config_value1),
        .config_value2 (config_value2),
        .config_done   (config_done),
        .config_error  (config_error),
        .resp_valid    (resp_valid),
        .resp_code     (resp_code),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (config_valid === 1'b1) begin
            cv_count = cv_count + 1;
            cv_cyc   = cyc;
            cv_type  = config_type;
            cv_v1    = config_value1;
            cv_v2    = config_value2;
        end
        if (resp_valid === 1'b1) begin
            rv_count = rv_count + 1;
            rv_cyc   = cyc;
            rv_code  = resp_code;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
        end
    endtask

    // mode: 0 = answer done, 1 = answer error, 2 = no answer, 3 = done and error together
    task automatic do_line(input string s, input int mode);
        int  cv0;
        int  rv0;
        bit  got;
        bit  pending;
        cv0     = cv_count;
        rv0     = rv_count;
        got     = 1'b0;
        pending = 1'b0;
        send_line(s);
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            config_done  = 1'b0;
            config_error = 1'b0;
            if (pending) begin
                config_done  = (mode == 0) || (mode == 3);
                config_error = (mode == 1) || (mode == 3);
                pending      = 1'b0;
            end
            if (config_valid === 1'b1) pending = (mode != 2);
            if (resp_valid === 1'b1) got = 1'b1;
        end
        @(negedge clk);
        config_done  = 1'b0;
        config_error = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (!got) $display("FAIL resp_wait line=%s no resp_valid within 60 cycles", s);
        else passed++;
        d_cv = cv_count - cv0;
        d_rv = rv_count - rv0;
        $display("line %-14s cmds=%0d type=%0d v1=%02h v2=%02h resps=%0d code=%0d",
                 s.substr(0, s.len() - 2), d_cv, cv_type, cv_v1, cv_v2, d_rv, rv_code);
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        rx_data      = 8'd0;
        rx_valid     = 1'b0;
        config_done  = 1'b0;
        config_error = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({config_valid, config_type, config_value1, config_value2, resp_valid, resp_code, busy} !== 24'd0)
            $display("FAIL reset_outputs got=%h want=0",
                     {config_valid, config_type, config_value1, config_value2, resp_valid, resp_code, busy});
        else passed++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_basic();
        do_line("C2 30\015", 0);
        total++;
        if (d_cv !== 1 || cv_type !== 3'd2 || cv_v1 !== 8'h1E || cv_v2 !== 8'h00)
            $display("FAIL basic_cmd got n=%0d t=%0d %h %h want n=1 t=2 1e 00", d_cv, cv_type, cv_v1, cv_v2);
        else passed++;
        total++;
        if (d_rv !== 1 || rv_code !== 2'd0)
            $display("FAIL basic_resp got n=%0d code=%0d want n=1 code=0", d_rv, rv_code);
        else passed++;
    endtask

    task automatic test_two_fields();
        do_line("c1 -5  12\012", 0);
        total++;
        if (d_cv !== 1 || cv_type !== 3'd1 || cv_v1 !== 8'hFB || cv_v2 !== 8'h0C || rv_code !== 2'd0)
            $display("FAIL two_fields got t=%0d %h %h code=%0d want t=1 fb 0c code=0",
                     cv_type, cv_v1, cv_v2, rv_code);
        else passed++;
        do_line("C6 1 2  \015", 0);
        total++;
        if (d_cv !== 1 || cv_type !== 3'd6 || cv_v1 !== 8'h01 || cv_v2 !== 8'h02 || rv_code !== 2'd0)
            $display("FAIL trailing_spaces got t=%0d %h %h code=%0d want t=6 01 02 code=0",
                     cv_type, cv_v1, cv_v2, rv_code);
        else passed++;
        total++;
        if (config_type !== 3'd6 || config_value1 !== 8'sh01 || config_value2 !== 8'sh02)
            $display("FAIL config_hold got t=%0d %h %h want t=6 01 02", config_type, config_value1, config_value2);
        else passed++;
    endtask

    task automatic test_boundaries();
        do_line("C1 -128 127\015", 0);
        total++;
        if (d_cv !== 1 || cv_v1 !== 8'h80 || cv_v2 !== 8'h7F || rv_code !== 2'd0)
            $display("FAIL bound_ok got n=%0d %h %h code=%0d want n=1 80 7f code=0", d_cv, cv_v1, cv_v2, rv_code);
        else passed++;
        do_line("C0 128\015", 0);
        total++;
        if (d_cv !== 0 || d_rv !== 1 || rv_code !== 2'd2)
            $display("FAIL bound_pos got n=%0d code=%0d want n=0 code=2", d_cv, rv_code);
        else passed++;
        do_line("C0 -129\015", 0);
        total++;
        if (d_cv !== 0 || d_rv !== 1 || rv_code !== 2'd2)
            $display("FAIL bound_neg got n=%0d code=%0d want n=0 code=2", d_cv, rv_code);
        else passed++;
    endtask

    task automatic test_parse_errors();
        string bad [4];
        bad[0] = "CX 5\015";
        bad[1] = "C2 1234\015";
        bad[2] = "C2 5 6 7\015";
        bad[3] = "C2 -\015";
        foreach (bad[i]) begin
            do_line(bad[i], 0);
            total++;
            if (d_cv !== 0 || d_rv !== 1 || rv_code !== 2'd2)
                $display("FAIL parse_err_%0d got n=%0d code=%0d want n=0 code=2", i, d_cv, rv_code);
            else passed++;
        end
        do_line("C2 5\015", 0);
        total++;
        if (d_cv !== 1 || cv_type !== 3'd2 || cv_v1 !== 8'h05 || cv_v2 !== 8'h00 || rv_code !== 2'd0)
            $display("FAIL after_error got n=%0d t=%0d %h %h code=%0d want n=1 t=2 05 00 code=0",
                     d_cv, cv_type, cv_v1, cv_v2, rv_code);
        else passed++;
    endtask

    task automatic test_config_error();
        do_line("C3\015", 1);
        total++;
        if (d_cv !== 1 || cv_type !== 3'd3 || cv_v1 !== 8'h00 || rv_code !== 2'd1)
            $display("FAIL cfg_error got n=%0d t=%0d %h code=%0d want n=1 t=3 00 code=1",
                     d_cv, cv_type, cv_v1, rv_code);
        else passed++;
        do_line("C4 7 -7\015", 3);
        total++;
        if (cv_v1 !== 8'h07 || cv_v2 !== 8'hF9 || rv_code !== 2'd1)
            $display("FAIL both_strobes got %h %h code=%0d want 07 f9 code=1", cv_v1, cv_v2, rv_code);
        else passed++;
    endtask

    task automatic test_timeout();
        int  cv0;
        int  rv0;
        bit  got;
        cv0 = cv_count;
        rv0 = rv_count;
        got = 1'b0;
        send_line("C3\015");
        @(negedge clk);
        total++;
        if (busy !== 1'b1) $display("FAIL busy_issue got=%b want=1", busy);
        else passed++;
        send_line("C5\015");
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) got = 1'b1;
        end
        repeat (3) @(negedge clk);
        total++;
        if (!got || rv_code !== 2'd3 || (rv_cyc - cv_cyc) !== 16)
            $display("FAIL timeout got seen=%0d code=%0d delay=%0d want seen=1 code=3 delay=16",
                     got, rv_code, rv_cyc - cv_cyc);
        else passed++;
        total++;
        if ((cv_count - cv0) !== 1 || (rv_count - rv0) !== 1 || resp_valid !== 1'b0 ||
            resp_code !== 2'd3 || busy !== 1'b0)
            $display("FAIL busy_drop got cmds=%0d resps=%0d rv=%b code=%0d busy=%b want 1 1 0 3 0",
                     cv_count - cv0, rv_count - rv0, resp_valid, resp_code, busy);
        else passed++;
        $display("line C3 (timeout) resp delay=%0d code=%0d", rv_cyc - cv_cyc, rv_code);
    endtask

    task automatic test_reset_midline();
        int cv0;
        int rv0;
        cv0 = cv_count;
        rv0 = rv_count;
        send_line("C1 -1");
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        total++;
        if ({config_valid, config_type, config_value1, config_value2, resp_valid, resp_code, busy} !== 24'd0)
            $display("FAIL async_reset got=%h want=0",
                     {config_valid, config_type, config_value1, config_value2, resp_valid, resp_code, busy});
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        send_line("2\015");
        repeat (20) @(negedge clk);
        total++;
        if ((cv_count - cv0) !== 0 || (rv_count - rv0) !== 0 ||
            {config_valid, config_type, config_value1, config_value2, resp_valid, resp_code, busy} !== 24'd0)
            $display("FAIL reset_midline got cmds=%0d resps=%0d outs=%h want 0 0 0",
                     cv_count - cv0, rv_count - rv0,
                     {config_valid, config_type, config_value1, config_value2, resp_valid, resp_code, busy});
        else passed++;
        $display("line C1 -1 <reset> 2 cmds=%0d resps=%0d", cv_count - cv0, rv_count - rv0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_two_fields();
        test_boundaries();
        test_parse_errors();
        test_config_error();
        test_timeout();
        test_reset_midline();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
